id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

Parametrised ID/EX pipeline register sitting between the decoder/register-file/control-unit stage and the ALU stage. It captures operands, immediate, ALU op, write-back and data-cache control, source register addresses and opcode on each clock. Unlike the plain capture register it carries a valid bit, supports stall (hold) and flush (bubble insertion) from the hazard unit, and suppresses writes to register x0. It can optionally bypass a same-cycle register-file write-back into the captured operands.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- REG_ADDR_W, 5, register address width
- OPCODE_W, 7, opcode width
- ALU_OP_W, 4, ALU control bus width
- DC_CTRL_W, 3, data-cache control bus width; value 0 means "no memory access"

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  hazard unit: hold current contents
- flush  in  1  hazard unit: load a bubble
- valid_in  in  1  decode stage holds a real instruction
- dataReg1 / dataReg2  in  DATA_W  register-file read data
- immValueIn  in  DATA_W  immediate
- opCodeFromDec  in  OPCODE_W  opcode
- writeBackAddrIn, dataS1AddrIn, dataS2AddrIn  in  REG_ADDR_W  rd, rs1, rs2
- ALUop  in  ALU_OP_W  ALU control
- writeEnableReg  in  1  register write-back enable
- dataCacheControlIn  in  DC_CTRL_W  memory control
- wbWriteEnable  in  1  write-back stage write enable (bypass only)
- wbAddr  in  REG_ADDR_W  write-back destination (bypass only)
- wbData  in  DATA_W  write-back data (bypass only)
- valid_out  out  1  EX stage holds a real instruction
- dataAlu1, dataAlu2, immValueOut  out  DATA_W  registered operands/immediate
- op  out  ALU_OP_W; opCodeToHazard  out  OPCODE_W
- writeEnableAlu  out  1; dataCacheControlOut  out  DC_CTRL_W
- writeBackAddrOut, dataS1AddrOut, dataS2AddrOut  out  REG_ADDR_W

## Operation
- Per-edge priority: rst > flush > stall > load.
- rst: every output 0 (valid_out=0, writeEnableAlu=0, dataCacheControlOut=0, all data/address/op fields 0).
- flush (stall ignored): bubble — valid_out=0, writeEnableAlu=0, dataCacheControlOut=0; all other fields also cleared to 0.
- stall (no flush): all outputs hold, except bypass update below.
- load: all fields captured from inputs; valid_out=valid_in.
- Load with valid_in=0: captured as bubble (writeEnableAlu=0, dataCacheControlOut=0), other fields captured as-is.
- x0 suppression: writeEnableAlu captured as 0 whenever writeBackAddrIn==0.
- No internal state beyond the output registers (plus nothing else).

## Timing
- Latency 1 cycle: inputs at edge N visible on outputs after edge N.
- stall held K cycles → outputs frozen K cycles; load resumes on first edge with stall=0.
- flush and stall same cycle → bubble.
- rst asserted mid-stall → cleared on that edge; next edge with rst=0 loads normally.
- No handshake; stall/flush must be stable before the rising edge.

## Configuration
- Macro ID_EX_WB_BYPASS_EN.
- Defined: on load, if wbWriteEnable && wbAddr!=0 && wbAddr==dataS1AddrIn, dataAlu1 takes wbData instead of dataReg1; same for rs2/dataAlu2. During stall with valid_out=1, if wbWriteEnable && wbAddr!=0 && wbAddr==dataS1AddrOut, dataAlu1 is updated to wbData (likewise rs2); other fields still hold. Flush/rst unaffected.
- Undefined: wb* ports present but ignored; operands always from dataReg1/dataReg2; held operands never change during stall.

## Test plan
- Reset: rst=1 one edge with all inputs nonzero → every output 0, valid_out=0.
- Load: valid_in=1, dataReg1=0x11, dataReg2=0x22, imm=0x4, rd=3, ALUop=2, writeEnableReg=1 → next cycle same values, writeEnableAlu=1, valid_out=1.
- Stall/flush: load A, stall 3 cycles with new inputs B → outputs stay A; assert stall+flush → valid_out=0, writeEnableAlu=0, dataCacheControlOut=0; then load B → B appears.
- x0: writeBackAddrIn=0, writeEnableReg=1, valid_in=1 → writeEnableAlu=0, valid_out=1.
- Bypass (EN defined): dataS1AddrIn=5, dataReg1=0x1, wbWriteEnable=1, wbAddr=5, wbData=0xABCD → dataAlu1=0xABCD; wbAddr=0 same case → dataAlu1=0x1; stalled with dataS2AddrOut=7, wb to 7 data 0x55 → dataAlu2=0x55.
- Bypass (EN undefined): same stimulus → dataAlu1=0x1, stalled dataAlu2 unchanged.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with valid, stall/flush and x0 write suppression.
// Define ID_EX_WB_BYPASS_EN to forward a same-cycle write-back into captured/held operands.
module id_ex_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 7,
  parameter int ALU_OP_W   = 4,
  parameter int DC_CTRL_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     dataReg1,
  input  logic [DATA_W-1:0]     dataReg2,
  input  logic [DATA_W-1:0]     immValueIn,
  input  logic [OPCODE_W-1:0]   opCodeFromDec,
  input  logic [REG_ADDR_W-1:0] writeBackAddrIn,
  input  logic [REG_ADDR_W-1:0] dataS1AddrIn,
  input  logic [REG_ADDR_W-1:0] dataS2AddrIn,
  input  logic [ALU_OP_W-1:0]   ALUop,
  input  logic                  writeEnableReg,
  input  logic [DC_CTRL_W-1:0]  dataCacheControlIn,
  input  logic                  wbWriteEnable,
  input  logic [REG_ADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0]     wbData,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     dataAlu1,
  output logic [DATA_W-1:0]     dataAlu2,
  output logic [DATA_W-1:0]     immValueOut,
  output logic [ALU_OP_W-1:0]   op,
  output logic [OPCODE_W-1:0]   opCodeToHazard,
  output logic                  writeEnableAlu,
  output logic [DC_CTRL_W-1:0]  dataCacheControlOut,
  output logic [REG_ADDR_W-1:0] writeBackAddrOut,
  output logic [REG_ADDR_W-1:0] dataS1AddrOut,
  output logic [REG_ADDR_W-1:0] dataS2AddrOut
);
  logic                  valid_q, valid_d, we_q, we_d;
  logic [DATA_W-1:0]     a1_q, a1_d, a2_q, a2_d, imm_q, imm_d;
  logic [ALU_OP_W-1:0]   op_q, op_d;
  logic [OPCODE_W-1:0]   opc_q, opc_d;
  logic [DC_CTRL_W-1:0]  dc_q, dc_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d, s1_q, s1_d, s2_q, s2_d;
  logic [DATA_W-1:0]     op1_in, op2_in, op1_hold, op2_hold;
`ifdef ID_EX_WB_BYPASS_EN
  logic wb_ok;
  assign wb_ok    = wbWriteEnable && wbAddr != '0;
  assign op1_in   = (wb_ok && wbAddr == dataS1AddrIn) ? wbData : dataReg1;
  assign op2_in   = (wb_ok && wbAddr == dataS2AddrIn) ? wbData : dataReg2;
  assign op1_hold = (valid_q && wb_ok && wbAddr == s1_q) ? wbData : a1_q;
  assign op2_hold = (valid_q && wb_ok && wbAddr == s2_q) ? wbData : a2_q;
`else
  logic unused_wb;
  assign unused_wb = ^{wbWriteEnable, wbAddr, wbData};
  assign op1_in    = dataReg1;
  assign op2_in    = dataReg2;
  assign op1_hold  = a1_q;
  assign op2_hold  = a2_q;
`endif
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    a1_d    = op1_hold;
    a2_d    = op2_hold;
    imm_d   = imm_q;
    op_d    = op_q;
    opc_d   = opc_q;
    dc_d    = dc_q;
    rd_d    = rd_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      a1_d    = '0;
      a2_d    = '0;
      imm_d   = '0;
      op_d    = '0;
      opc_d   = '0;
      dc_d    = '0;
      rd_d    = '0;
      s1_d    = '0;
      s2_d    = '0;
    end else if (!stall) begin
      valid_d = valid_in;
      we_d    = valid_in && writeEnableReg && writeBackAddrIn != '0;
      a1_d    = op1_in;
      a2_d    = op2_in;
      imm_d   = immValueIn;
      op_d    = ALUop;
      opc_d   = opCodeFromDec;
      dc_d    = valid_in ? dataCacheControlIn : '0;
      rd_d    = writeBackAddrIn;
      s1_d    = dataS1AddrIn;
      s2_d    = dataS2AddrIn;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      imm_q   <= '0;
      op_q    <= '0;
      opc_q   <= '0;
      dc_q    <= '0;
      rd_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      imm_q   <= imm_d;
      op_q    <= op_d;
      opc_q   <= opc_d;
      dc_q    <= dc_d;
      rd_q    <= rd_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end
  assign valid_out           = valid_q;
  assign writeEnableAlu      = we_q;
  assign dataAlu1            = a1_q;
  assign dataAlu2            = a2_q;
  assign immValueOut         = imm_q;
  assign op                  = op_q;
  assign opCodeToHazard      = opc_q;
  assign dataCacheControlOut = dc_q;
  assign writeBackAddrOut    = rd_q;
  assign dataS1AddrOut       = s1_q;
  assign dataS2AddrOut       = s2_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: randomized self-checking bench for id_ex_pipe_reg against a behavioural model.
module tb_id_ex_pipe_reg;
  typedef struct packed {
    logic        v;
    logic [31:0] a1, a2, imm;
    logic [3:0]  op;
    logic [6:0]  opc;
    logic        we;
    logic [2:0]  dc;
    logic [4:0]  rd, s1, s2;
  } out_t;
  logic clk = 0, rst = 0, stall = 0, flush = 0, valid_in = 0;
  logic [31:0] dataReg1 = 0, dataReg2 = 0, immValueIn = 0, wbData = 0;
  logic [6:0]  opCodeFromDec = 0;
  logic [4:0]  writeBackAddrIn = 0, dataS1AddrIn = 0, dataS2AddrIn = 0, wbAddr = 0;
  logic [3:0]  ALUop = 0;
  logic        writeEnableReg = 0, wbWriteEnable = 0;
  logic [2:0]  dataCacheControlIn = 0;
  logic        valid_out, writeEnableAlu;
  logic [31:0] dataAlu1, dataAlu2, immValueOut;
  logic [3:0]  op;
  logic [6:0]  opCodeToHazard;
  logic [2:0]  dataCacheControlOut;
  logic [4:0]  writeBackAddrOut, dataS1AddrOut, dataS2AddrOut;
  out_t got, m, snap;
  int vectors = 0, errors = 0;
  bit bypass_en;
  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .dataReg1(dataReg1), .dataReg2(dataReg2), .immValueIn(immValueIn),
    .opCodeFromDec(opCodeFromDec), .writeBackAddrIn(writeBackAddrIn),
    .dataS1AddrIn(dataS1AddrIn), .dataS2AddrIn(dataS2AddrIn), .ALUop(ALUop),
    .writeEnableReg(writeEnableReg), .dataCacheControlIn(dataCacheControlIn),
    .wbWriteEnable(wbWriteEnable), .wbAddr(wbAddr), .wbData(wbData),
    .valid_out(valid_out), .dataAlu1(dataAlu1), .dataAlu2(dataAlu2),
    .immValueOut(immValueOut), .op(op), .opCodeToHazard(opCodeToHazard),
    .writeEnableAlu(writeEnableAlu), .dataCacheControlOut(dataCacheControlOut),
    .writeBackAddrOut(writeBackAddrOut), .dataS1AddrOut(dataS1AddrOut),
    .dataS2AddrOut(dataS2AddrOut)
  );
  assign got = {valid_out, dataAlu1, dataAlu2, immValueOut, op, opCodeToHazard,
                writeEnableAlu, dataCacheControlOut, writeBackAddrOut, dataS1AddrOut, dataS2AddrOut};
  always #5 clk = ~clk;
  // Model: what the EX stage should see after the coming edge, from the rules alone.
  function automatic out_t predict(out_t cur);
    out_t n = cur;
    bit hit = bypass_en && wbWriteEnable && wbAddr != 0;
    if (rst || flush) return '0;
    if (stall) begin
      if (hit && cur.v && wbAddr == cur.s1) n.a1 = wbData;
      if (hit && cur.v && wbAddr == cur.s2) n.a2 = wbData;
      return n;
    end
    n.v   = valid_in;
    n.a1  = (hit && wbAddr == dataS1AddrIn) ? wbData : dataReg1;
    n.a2  = (hit && wbAddr == dataS2AddrIn) ? wbData : dataReg2;
    n.imm = immValueIn;
    n.op  = ALUop;
    n.opc = opCodeFromDec;
    n.we  = valid_in && writeEnableReg && (writeBackAddrIn != 0);
    n.dc  = valid_in ? dataCacheControlIn : 3'd0;
    n.rd  = writeBackAddrIn;
    n.s1  = dataS1AddrIn;
    n.s2  = dataS2AddrIn;
    return n;
  endfunction
  task automatic tick();
    out_t n = predict(m);
    @(posedge clk);
    m = n;
    #1;
  endtask
  task automatic rand_inputs(int addr_max);
    valid_in = 1'($urandom);
    dataReg1 = $urandom; dataReg2 = $urandom; immValueIn = $urandom; wbData = $urandom;
    opCodeFromDec = 7'($urandom);
    writeBackAddrIn = 5'($urandom_range(0, addr_max));
    dataS1AddrIn = 5'($urandom_range(0, addr_max));
    dataS2AddrIn = 5'($urandom_range(0, addr_max));
    wbAddr = 5'($urandom_range(0, addr_max));
    ALUop = 4'($urandom); writeEnableReg = 1'($urandom);
    wbWriteEnable = 1'($urandom); dataCacheControlIn = 3'($urandom);
  endtask
  task automatic test_reset();
    rand_inputs(31);
    valid_in = 1; writeEnableReg = 1; writeBackAddrIn = 5'd9; dataCacheControlIn = 3'd5;
    rst = 1; stall = 1; flush = 0;
    tick();
    rst = 0; stall = 0;
    vectors++;
    if (got !== out_t'(0)) begin errors++; $display("FAIL reset_all: got %h want %h", got, out_t'(0)); end
    vectors++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
  endtask
  task automatic test_load();
    rand_inputs(31);
    wbWriteEnable = 0; valid_in = 1; dataReg1 = 32'h11; dataReg2 = 32'h22; immValueIn = 32'h4;
    writeBackAddrIn = 5'd3; ALUop = 4'd2; writeEnableReg = 1;
    tick();
    vectors++;
    if ({dataAlu1, dataAlu2, immValueOut} !== {32'h11, 32'h22, 32'h4}) begin
      errors++; $display("FAIL load_data: got %h %h %h want 11 22 4", dataAlu1, dataAlu2, immValueOut);
    end
    vectors++;
    if ({writeBackAddrOut, op, writeEnableAlu, valid_out} !== {5'd3, 4'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL load_ctrl: got rd=%0d op=%0d we=%b v=%b want 3 2 1 1",
                         writeBackAddrOut, op, writeEnableAlu, valid_out);
    end
    vectors++;
    if (got !== m) begin errors++; $display("FAIL load_all: got %h want %h", got, m); end
  endtask
  task automatic test_stall_flush();
    rand_inputs(31);
    valid_in = 1; writeEnableReg = 1; writeBackAddrIn = 5'd6; dataCacheControlIn = 3'd2;
    tick();
    snap = m;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(31);
      wbWriteEnable = 0; stall = 1;
      tick();
      vectors++;
      if (got !== snap) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", i, got, snap); end
    end
    flush = 1;
    tick();
    vectors++;
    if ({valid_out, writeEnableAlu, dataCacheControlOut} !== 5'b0) begin
      errors++; $display("FAIL flush_bubble: got v=%b we=%b dc=%0d want 0 0 0",
                         valid_out, writeEnableAlu, dataCacheControlOut);
    end
    vectors++;
    if (got !== out_t'(0)) begin errors++; $display("FAIL flush_all: got %h want 0", got); end
    flush = 0; stall = 0; valid_in = 1; writeEnableReg = 1; writeBackAddrIn = 5'd12;
    tick();
    vectors++;
    if (got !== m || dataAlu1 !== dataReg1 || valid_out !== 1'b1) begin
      errors++; $display("FAIL after_flush_load: got %h want %h", got, m);
    end
  endtask
  task automatic test_x0();
    rand_inputs(31);
    valid_in = 1; writeEnableReg = 1; writeBackAddrIn = 0;
    tick();
    vectors++;
    if ({writeEnableAlu, valid_out} !== 2'b01) begin
      errors++; $display("FAIL x0_suppress: got we=%b v=%b want we=0 v=1", writeEnableAlu, valid_out);
    end
    valid_in = 0; writeBackAddrIn = 5'd4; dataCacheControlIn = 3'd7;
    tick();
    vectors++;
    if ({writeEnableAlu, dataCacheControlOut, valid_out, writeBackAddrOut} !== {1'b0, 3'd0, 1'b0, 5'd4}) begin
      errors++; $display("FAIL invalid_bubble: got we=%b dc=%0d v=%b rd=%0d want 0 0 0 4",
                         writeEnableAlu, dataCacheControlOut, valid_out, writeBackAddrOut);
    end
  endtask
  task automatic test_bypass();
    rand_inputs(31);
    valid_in = 1; dataS1AddrIn = 5'd5; dataReg1 = 32'h1;
    wbWriteEnable = 1; wbAddr = 5'd5; wbData = 32'hABCD;
    tick();
    vectors++;
    if (dataAlu1 !== (bypass_en ? 32'hABCD : 32'h1)) begin
      errors++; $display("FAIL bypass_load: got %h want %h", dataAlu1, bypass_en ? 32'hABCD : 32'h1);
    end
    wbAddr = 0; dataS1AddrIn = 0;
    tick();
    vectors++;
    if (dataAlu1 !== 32'h1) begin errors++; $display("FAIL bypass_x0: got %h want 1", dataAlu1); end
    wbWriteEnable = 0; valid_in = 1; dataS2AddrIn = 5'd7; dataS1AddrIn = 5'd8; dataReg2 = 32'h99;
    tick();
    stall = 1; wbWriteEnable = 1; wbAddr = 5'd7; wbData = 32'h55; dataReg2 = 32'h77;
    tick();
    stall = 0;
    vectors++;
    if (dataAlu2 !== (bypass_en ? 32'h55 : 32'h99) || dataAlu1 !== 32'h1) begin
      errors++; $display("FAIL bypass_stall: got a2=%h a1=%h want a2=%h a1=1",
                         dataAlu2, dataAlu1, bypass_en ? 32'h55 : 32'h99);
    end
  endtask
  task automatic test_rst_mid_stall();
    rand_inputs(31);
    valid_in = 1; tick();
    stall = 1; tick();
    rst = 1; tick();
    vectors++;
    if (got !== out_t'(0)) begin errors++; $display("FAIL rst_mid_stall: got %h want 0", got); end
    rst = 0; stall = 0; rand_inputs(31); valid_in = 1;
    tick();
    vectors++;
    if (got !== m || valid_out !== 1'b1) begin errors++; $display("FAIL rst_then_load: got %h want %h", got, m); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs(7);
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 9) < 3);
      tick();
      vectors++;
      if (got !== m) begin errors++; $display("FAIL random%0d: got %h want %h", i, got, m); end
    end
    rst = 0; flush = 0; stall = 0;
  endtask
  initial begin
`ifdef ID_EX_WB_BYPASS_EN
    bypass_en = 1;
`else
    bypass_en = 0;
`endif
    m = '0;
    test_reset();
    test_load();
    test_stall_flush();
    test_x0();
    test_bypass();
    test_rst_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
